// File: rtl/tx_client_responder.sv
// MAC-side sink for the client transmit handshake: delayed ack, per-frame length/sum/status, inter-frame gap.
// Optional: define TX_CRC32_EN to add the frame_crc output (Ethernet CRC-32 of every accepted byte).
module tx_client_responder #(
  parameter int ACK_DELAY  = 4,
  parameter int IFG_CYCLES = 12,
  parameter int MIN_LEN    = 60,
  parameter int MAX_LEN    = 1514
) (
  input  logic        tx_clk,
  input  logic        reset_b,
  input  logic [7:0]  tx_data,
  input  logic        tx_data_valid,
  output logic        tx_ack,
  output logic [7:0]  byte_out,
  output logic        byte_out_valid,
  output logic        frame_done,
  output logic [15:0] frame_len,
  output logic [15:0] frame_sum,
  output logic        frame_short,
  output logic        frame_long,
  output logic        abort_pulse,
  output logic [15:0] frame_count
`ifdef TX_CRC32_EN
  ,
  output logic [31:0] frame_crc
`endif
);

  typedef enum logic [1:0] {IDLE, DELAY, DATA, GAP} state_t;

  localparam logic [7:0]  DLY_LOAD = 8'(ACK_DELAY - 1);
  localparam logic [7:0]  IFG_LOAD = 8'(IFG_CYCLES - 1);
  localparam logic [15:0] MIN_L    = 16'(MIN_LEN);
  localparam logic [15:0] MAX_L    = 16'(MAX_LEN);

  state_t      state, state_nxt;
  logic [7:0]  dly_cnt, gap_cnt;
  logic [15:0] len_acc, sum_acc;
  logic        start_dly, ack_take, accept_more, frame_end, abort_det;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge tx_clk or negedge reset_b) begin
    if (!reset_b) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (tx_data_valid) state_nxt = DELAY;
      DELAY: begin
        if (!tx_data_valid)     state_nxt = IDLE;
        else if (dly_cnt == '0) state_nxt = DATA;
      end
      DATA:  if (!tx_data_valid) state_nxt = GAP;
      GAP:   if (gap_cnt == '0)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Valid seen during GAP is deliberately not decoded: it is re-sampled once back in IDLE.
  always_comb begin
    start_dly   = 1'b0;
    ack_take    = 1'b0;
    accept_more = 1'b0;
    frame_end   = 1'b0;
    abort_det   = 1'b0;
    case (state)
      IDLE:  start_dly = tx_data_valid;
      DELAY: begin
        abort_det = !tx_data_valid;
        ack_take  = tx_data_valid && (dly_cnt == '0);
      end
      DATA: begin
        accept_more = tx_data_valid;
        frame_end   = !tx_data_valid;
      end
      default: ;
    endcase
  end

  assign tx_ack = ack_take;

  always_ff @(posedge tx_clk or negedge reset_b) begin
    if (!reset_b) begin
      dly_cnt <= '0;
      gap_cnt <= '0;
    end else begin
      if (start_dly)                            dly_cnt <= DLY_LOAD;
      else if (state == DELAY && dly_cnt != '0) dly_cnt <= dly_cnt - 8'd1;
      if (frame_end)                            gap_cnt <= IFG_LOAD;
      else if (state == GAP && gap_cnt != '0)   gap_cnt <= gap_cnt - 8'd1;
    end
  end

  // Stage p0 -> p1: accumulate the accepted byte and present its registered copy.
  always_ff @(posedge tx_clk or negedge reset_b) begin
    if (!reset_b) begin
      len_acc        <= '0;
      sum_acc        <= '0;
      byte_out       <= '0;
      byte_out_valid <= 1'b0;
    end else begin
      byte_out_valid <= ack_take || accept_more;
      if (ack_take || accept_more) byte_out <= tx_data;
      if (ack_take) begin
        len_acc <= 16'd1;
        sum_acc <= 16'(tx_data);
      end else if (accept_more) begin
        len_acc <= sat_inc(len_acc);
        sum_acc <= sum_acc + 16'(tx_data);
      end
    end
  end

  // Stage p1 -> p2: latch per-frame results on the cycle after valid drops.
  always_ff @(posedge tx_clk or negedge reset_b) begin
    if (!reset_b) begin
      frame_done  <= 1'b0;
      abort_pulse <= 1'b0;
      frame_len   <= '0;
      frame_sum   <= '0;
      frame_short <= 1'b0;
      frame_long  <= 1'b0;
      frame_count <= '0;
    end else begin
      frame_done  <= frame_end;
      abort_pulse <= abort_det;
      if (frame_end) begin
        frame_len   <= len_acc;
        frame_sum   <= sum_acc;
        frame_short <= len_acc < MIN_L;
        frame_long  <= len_acc > MAX_L;
        frame_count <= frame_count + 16'd1;
      end
    end
  end

`ifdef TX_CRC32_EN
  logic [31:0] crc_acc;

  // Reflected CRC-32 (poly 0x04C11DB7 reversed), one byte per call.
  function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++)
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  always_ff @(posedge tx_clk or negedge reset_b) begin
    if (!reset_b) begin
      crc_acc   <= '0;
      frame_crc <= '0;
    end else begin
      if (ack_take)         crc_acc <= crc32_byte(32'hFFFFFFFF, tx_data);
      else if (accept_more) crc_acc <= crc32_byte(crc_acc, tx_data);
      if (frame_end)        frame_crc <= ~crc_acc;
    end
  end
`endif

endmodule

// File: tb/tb_tx_client_responder.sv
// Scoreboard bench for tx_client_responder: drivers queue expected bytes/frames, a negedge monitor checks them.
module tb_tx_client_responder;

  localparam int ACK_DELAY  = 4;
  localparam int IFG_CYCLES = 12;

  logic        tx_clk = 1'b0;
  logic        reset_b;
  logic [7:0]  tx_data;
  logic        tx_data_valid;
  logic        tx_ack;
  logic [7:0]  byte_out;
  logic        byte_out_valid;
  logic        frame_done;
  logic [15:0] frame_len;
  logic [15:0] frame_sum;
  logic        frame_short;
  logic        frame_long;
  logic        abort_pulse;
  logic [15:0] frame_count;
`ifdef TX_CRC32_EN
  logic [31:0] frame_crc;
`endif

  tx_client_responder dut (
    .tx_clk         (tx_clk),
    .reset_b        (reset_b),
    .tx_data        (tx_data),
    .tx_data_valid  (tx_data_valid),
    .tx_ack         (tx_ack),
    .byte_out       (byte_out),
    .byte_out_valid (byte_out_valid),
    .frame_done     (frame_done),
    .frame_len      (frame_len),
    .frame_sum      (frame_sum),
    .frame_short    (frame_short),
    .frame_long     (frame_long),
    .abort_pulse    (abort_pulse),
    .frame_count    (frame_count)
`ifdef TX_CRC32_EN
    ,
    .frame_crc      (frame_crc)
`endif
  );

  always #5 tx_clk = ~tx_clk;

  typedef struct {
    logic [15:0] len;
    logic [15:0] sum;
    logic        sh;
    logic        lg;
    logic [15:0] cnt;
    logic        crc_chk;
    logic [31:0] crc;
  } frame_t;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [7:0]  bq[$];
  frame_t      fq[$];
  int          abort_exp = 0;
  int          ack_cnt   = 0;
  int          exp_acks  = 0;
  int          bytes_seen = 0;
  int          frame_no  = 0;
  logic        ack_prev  = 1'b0;
  logic [7:0]  exp_b;
  frame_t      f;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [7:0] byte_of(input int kind, input int i);
    case (kind)
      0:       return 8'(i);
      1:       return 8'hFF;
      default: return 8'(8'h31 + i);
    endcase
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge tx_clk);
    #1;
  endtask

  // rst_at > 0: drive that many bytes, then pull reset instead of ending the frame.
  task automatic send_frame(input int kind, input int n, input int exp_wait,
                            input logic [15:0] e_len, input logic [15:0] e_sum,
                            input logic e_sh, input logic e_lg,
                            input logic crc_chk, input logic [31:0] e_crc, input int rst_at);
    int c;
    bit got;
    int last;
    got  = 1'b0;
    last = (rst_at > 0) ? rst_at : n;
    exp_acks++;
    @(posedge tx_clk); #1;
    tx_data_valid = 1'b1;
    tx_data       = byte_of(kind, 0);
    for (c = 0; c < 200; c++) begin
      @(negedge tx_clk);
      if (tx_ack) begin
        got = 1'b1;
        break;
      end
      @(posedge tx_clk); #1;
    end
    chk("ack_latency", c, exp_wait);
    if (got) begin
      bq.push_back(byte_of(kind, 0));
      for (int i = 1; i < last; i++) begin
        @(posedge tx_clk); #1;
        tx_data = byte_of(kind, i);
        bq.push_back(tx_data);
      end
      if (rst_at == 0) begin
        frame_no++;
        fq.push_back('{e_len, e_sum, e_sh, e_lg, 16'(frame_no), crc_chk, e_crc});
      end
    end
    @(posedge tx_clk); #1;
    tx_data_valid = 1'b0;
    tx_data       = 8'h00;
    if (rst_at > 0) begin
      reset_b = 1'b0;
      bq.delete();
      frame_no = 0;
    end
  endtask

  always @(negedge tx_clk) begin
    if (!reset_b) begin
      ack_prev   = 1'b0;
      bytes_seen = 0;
    end else begin
      if (tx_ack) begin
        ack_cnt++;
        chk("ack_single_cycle", ack_prev, 0);
      end
      ack_prev = tx_ack;
      if (byte_out_valid) begin
        bytes_seen++;
        if (bq.size() == 0) chk("byte_unexpected", byte_out_valid, 0);
        else begin
          exp_b = bq.pop_front();
          chk("byte_out", byte_out, exp_b);
        end
      end
      if (abort_pulse) begin
        chk("abort_expected", abort_exp > 0, 1);
        if (abort_exp > 0) abort_exp--;
      end
      if (frame_done) begin
        if (fq.size() == 0) chk("frame_done_unexpected", frame_done, 0);
        else begin
          f = fq.pop_front();
          chk("frame_len",   frame_len,   f.len);
          chk("frame_sum",   frame_sum,   f.sum);
          chk("frame_short", frame_short, f.sh);
          chk("frame_long",  frame_long,  f.lg);
          chk("frame_count", frame_count, f.cnt);
          chk("byte_pulses", bytes_seen,  f.len);
`ifdef TX_CRC32_EN
          if (f.crc_chk) chk("frame_crc", frame_crc, f.crc);
`endif
        end
        bytes_seen = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int acks0;
    reset_b       = 1'b0;
    tx_data       = 8'h00;
    tx_data_valid = 1'b0;
    repeat (3) @(negedge tx_clk);
    chk("rst_tx_ack",      tx_ack,         0);
    chk("rst_byte_valid",  byte_out_valid, 0);
    chk("rst_byte_out",    byte_out,       0);
    chk("rst_frame_done",  frame_done,     0);
    chk("rst_frame_len",   frame_len,      0);
    chk("rst_frame_sum",   frame_sum,      0);
    chk("rst_frame_short", frame_short,    0);
    chk("rst_frame_long",  frame_long,     0);
    chk("rst_abort",       abort_pulse,    0);
    chk("rst_frame_count", frame_count,    0);
    @(posedge tx_clk); #1;
    reset_b = 1'b1;
    idle(3);

    // 60-byte ramp, then a short 10-byte 0xFF frame
    send_frame(0, 60, ACK_DELAY, 16'd60, 16'h06EA, 1'b0, 1'b0, 1'b0, 32'h0, 0);
    idle(20);
    send_frame(1, 10, ACK_DELAY, 16'd10, 16'h09F6, 1'b1, 1'b0, 1'b0, 32'h0, 0);
    idle(20);

    // valid for two cycles only: abort, no ack, count unchanged
    acks0 = ack_cnt;
    tx_data_valid = 1'b1;
    tx_data       = 8'hA5;
    @(posedge tx_clk); #1;
    @(posedge tx_clk); #1;
    tx_data_valid = 1'b0;
    abort_exp++;
    idle(20);
    chk("abort_no_ack",     ack_cnt,     acks0);
    chk("abort_count_hold", frame_count, 2);
    chk("abort_seen",       abort_exp,   0);

    // back-to-back: second frame raises valid right after the end cycle
    send_frame(0, 60, ACK_DELAY, 16'd60, 16'h06EA, 1'b0, 1'b0, 1'b0, 32'h0, 0);
    send_frame(0, 60, IFG_CYCLES + ACK_DELAY, 16'd60, 16'h06EA, 1'b0, 1'b0, 1'b0, 32'h0, 0);
    idle(20);

    send_frame(0, 1600, ACK_DELAY, 16'd1600, 16'h04E0, 1'b0, 1'b1, 1'b0, 32'h0, 0);
    idle(20);

`ifdef TX_CRC32_EN
    send_frame(2, 9, ACK_DELAY, 16'd9, 16'h01DD, 1'b1, 1'b0, 1'b1, 32'hCBF43926, 0);
    idle(20);
`endif

    // repeat of the long frame with reset pulled mid-frame
    send_frame(0, 1600, ACK_DELAY, 16'd0, 16'h0, 1'b0, 1'b0, 1'b0, 32'h0, 500);
    #2;
    chk("midrst_byte_valid",  byte_out_valid, 0);
    chk("midrst_frame_done",  frame_done,     0);
    chk("midrst_frame_len",   frame_len,      0);
    chk("midrst_frame_sum",   frame_sum,      0);
    chk("midrst_frame_long",  frame_long,     0);
    chk("midrst_frame_count", frame_count,    0);
    idle(3);
    reset_b = 1'b1;
    idle(30);
    chk("post_rst_frame_count", frame_count, 0);
    chk("post_rst_frame_len",   frame_len,   0);

    chk("frames_left", fq.size(), 0);
    chk("bytes_left",  bq.size(), 0);
    chk("ack_total",   ack_cnt,   exp_acks);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/tx_client_responder.md
Name: tx_client_responder

Overview:
- MAC-side responder for the client transmit handshake driven by the camera frame transmitter (tx_data, tx_data_valid, tx_ack).
- Acknowledges each frame after a programmable delay and captures every byte.
- Reports length, checksum and error status per frame, and enforces an inter-frame gap.
- Used as the loopback/bring-up sink on tx_clk in place of the Ethernet core, and as a synthesizable checker in the bench.

Parameters:
- ACK_DELAY, 4: cycles from first sampled tx_data_valid=1 to tx_ack pulse; legal 1..255.
- IFG_CYCLES, 12: cycles after frame end during which no new frame is acknowledged; legal 1..255.
- MIN_LEN, 60: minimum legal frame length in bytes.
- MAX_LEN, 1514: maximum legal frame length in bytes.

Ports:
- tx_clk  in  1  sole clock, rising edge
- reset_b  in  1  asynchronous, active-low reset
- tx_data  in  8  byte from transmitter client
- tx_data_valid  in  1  frame-in-progress from client
- tx_ack  out  1  one-cycle acknowledge of first byte
- byte_out  out  8  registered copy of each accepted byte
- byte_out_valid  out  1  byte_out qualifier
- frame_done  out  1  one-cycle pulse after a completed frame
- frame_len  out  16  bytes in last completed frame
- frame_sum  out  16  mod-2^16 sum of bytes in last completed frame
- frame_short  out  1  last frame_len < MIN_LEN
- frame_long  out  1  last frame_len > MAX_LEN
- abort_pulse  out  1  one-cycle pulse: valid dropped before ack
- frame_count  out  16  completed frames, wraps 0xFFFF->0

Behaviour:
- Reset (reset_b=0, async) sets state IDLE and all outputs to 0. Counters and accumulators clear.
- States: IDLE, DELAY, DATA, GAP.
- IDLE: tx_data_valid=1 -> DELAY; delay counter loads ACK_DELAY-1.
- DELAY:
  - valid=0 before ack -> abort_pulse=1 next cycle, -> IDLE (no gap).
  - Counter reaches 0 with valid=1 -> tx_ack=1 for this cycle only. Byte 0 = tx_data sampled on the ack cycle. len=1, sum=byte 0. -> DATA.
  - Total: ack asserts exactly ACK_DELAY cycles after the first valid cycle is sampled.
- DATA:
  - Each cycle with valid=1 accepts tx_data: len+=1, sum+=byte.
  - First cycle with valid=0 ends the frame. Next cycle: frame_done=1 for one cycle. frame_len, frame_sum, frame_short and frame_long update and hold until the next frame_done. frame_count+=1. -> GAP.
- byte_out/byte_out_valid: 1-cycle latency from each accepted byte, including byte 0. Valid is never asserted outside accepted bytes.
- GAP: counts IFG_CYCLES cycles, then -> IDLE. Valid=1 during GAP is ignored (no ack, no capture) and is re-sampled in IDLE. A continuously held valid therefore gets its ack IFG_CYCLES+ACK_DELAY+1 cycles after frame end.
- Length counter saturates at 0xFFFF; frame_long still set. frame_sum wraps mod 2^16.
- frame_short/frame_long are status of the last frame only; both cannot be 1 together when MIN_LEN<=MAX_LEN.
- tx_ack is never asserted outside DELAY and never for two consecutive cycles.
- Reset mid-frame: immediate return to IDLE. No frame_done, no frame_count increment, partial frame discarded.

Optional Feature:
- TX_CRC32_EN defined:
  - Adds output frame_crc (32), Ethernet CRC-32 over all accepted bytes: reflected, poly 0x04C11DB7, init 0xFFFFFFFF, final XOR 0xFFFFFFFF.
  - One byte processed per cycle.
  - frame_crc updates with frame_done; reset value 0.
- Undefined: port frame_crc absent, no CRC logic.

Test Plan:
- Reset then 60-byte frame 0x00..0x3B, ACK_DELAY=4 -> tx_ack exactly 4 cycles after valid rises; frame_len=60, frame_sum=0x06EA, frame_short=0, frame_long=0, frame_count=1.
- 10-byte frame of 0xFF -> frame_len=10, frame_sum=0x09F6, frame_short=1; 60 byte_out_valid pulses not expected, exactly 10 seen.
- Valid asserted 2 cycles then dropped (ACK_DELAY=4) -> abort_pulse once, no tx_ack, frame_count unchanged.
- Back-to-back: valid reasserted immediately after a frame end -> no ack until IFG_CYCLES elapsed; second ack at 12+4+1=17 cycles after end.
- 1600-byte frame -> frame_long=1, frame_len=1600; reset_b pulsed low mid-frame on a repeat -> outputs 0, no frame_done.
- TX_CRC32_EN: frame ASCII "123456789" -> frame_crc=0xCBF43926.
